// File: rtl/tnn_feature_framer_if.sv
// Stream bundle for the feature framer: raw-sample input side and quantized-frame output side.
// The master drives samples and consumes frames; the slave is the framer itself.
interface tnn_feature_framer_if #(
    parameter int RAW_W  = 8,
    parameter int FEAT_W = 3,
    parameter int N_FEAT = 5
);
    logic [RAW_W-1:0]         in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] out_vec;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_vec, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_vec, out_valid
    );
endinterface

// File: rtl/tnn_feature_framer.sv
// Rounds raw samples to FEAT_W bits with saturation and packs N_FEAT of them into a
// registered frame for the ternary-neuron cores; one assembled frame can wait behind the output.
module tnn_feature_framer #(
    parameter int RAW_W  = 8,
    parameter int FEAT_W = 3,
    parameter int N_FEAT = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    tnn_feature_framer_if.slave  bus,
    output logic                 frame_err,
    output logic [7:0]           err_cnt,
    output logic [15:0]          frame_cnt
);
    localparam int SH    = RAW_W - FEAT_W;
    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [RAW_W:0]   RND_C    = (RAW_W+1)'(1) << (SH - 1);
    localparam logic [RAW_W:0]   SAT_C    = (RAW_W+1)'((1 << FEAT_W) - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Round-half-up at RAW_W+1 bits so the carry out of the rounding add is never lost.
    function automatic logic [FEAT_W-1:0] quantize(input logic [RAW_W-1:0] d);
        logic [RAW_W:0] sum;
        logic [RAW_W:0] q;
        sum = {1'b0, d} + RND_C;
        q   = sum >> SH;
        if (q > SAT_C) begin
            quantize = SAT_C[FEAT_W-1:0];
        end else begin
            quantize = q[FEAT_W-1:0];
        end
    endfunction

    state_t                               state_r, state_n;
    logic [IDX_W-1:0]                     idx_r, idx_n;
    logic [N_FEAT-1:0][FEAT_W-1:0]        asm_r;
    logic [N_FEAT-1:0][FEAT_W-1:0]        asm_next_s;
    logic [N_FEAT*FEAT_W-1:0]             out_vec_r;
    logic                                 out_valid_r;
    logic                                 err_r;
    logic [7:0]                           err_cnt_r;
    logic [15:0]                          frame_cnt_r;
    logic                                 ready_s;
    logic                                 beat_s;
    logic                                 pop_s;
    logic                                 wr_s;
    logic                                 ld_new_s;
    logic                                 ld_hold_s;
    logic                                 err_s;
    logic [FEAT_W-1:0]                    q_s;

    // Acceptance is a function of state only, so out_ready never reaches in_ready.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (state_r != ST_HOLD);
        end
    end

    assign beat_s = bus.in_valid && ready_s;
    assign pop_s  = out_valid_r && bus.out_ready;
    assign q_s    = quantize(bus.in_data);

    // Assembly view with the current beat already inserted, used when the last beat loads directly.
    always_comb begin
        asm_next_s        = asm_r;
        asm_next_s[idx_r] = q_s;
    end

    // FSM state and slot index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_COLLECT;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
        end
    end

    // Next-state and datapath strobes for framing, overflow into HOLD and resync in DRAIN.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        wr_s      = 1'b0;
        ld_new_s  = 1'b0;
        ld_hold_s = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (beat_s) begin
                    wr_s = 1'b1;
                    if (idx_r != LAST_IDX) begin
                        if (bus.in_last) begin
                            err_s = 1'b1;
                            idx_n = IDX_ZERO;
                        end else begin
                            idx_n = idx_r + IDX_W'(1);
                        end
                    end else begin
                        idx_n = IDX_ZERO;
                        if (bus.in_last) begin
                            if (!out_valid_r || pop_s) begin
                                ld_new_s = 1'b1;
                            end else begin
                                state_n = ST_HOLD;
                            end
                        end else begin
                            err_s   = 1'b1;
                            state_n = ST_DRAIN;
                        end
                    end
                end else begin
                    wr_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (pop_s) begin
                    ld_hold_s = 1'b1;
                    state_n   = ST_COLLECT;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (beat_s && bus.in_last) begin
                    idx_n   = IDX_ZERO;
                    state_n = ST_COLLECT;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                idx_n   = IDX_ZERO;
                state_n = ST_COLLECT;
            end
        endcase
    end

    // Assembly slots; cleared on reset so no stale samples survive.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_r <= '{default: {FEAT_W{1'b0}}};
        end else if (wr_s) begin
            asm_r[idx_r] <= q_s;
        end else begin
            asm_r <= asm_r;
        end
    end

    // Output frame register; a pop and a new load in the same cycle keep out_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vec_r   <= {(N_FEAT*FEAT_W){1'b0}};
            out_valid_r <= 1'b0;
        end else if (ld_new_s) begin
            out_vec_r   <= asm_next_s;
            out_valid_r <= 1'b1;
        end else if (ld_hold_s) begin
            out_vec_r   <= asm_r;
            out_valid_r <= 1'b1;
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Error pulse and status counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r       <= 1'b0;
            err_cnt_r   <= 8'd0;
            frame_cnt_r <= 16'd0;
        end else begin
            err_r <= err_s;
            if (err_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
            if (pop_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_vec   = out_vec_r;
    assign bus.out_valid = out_valid_r;
    assign frame_err     = err_r;
    assign err_cnt       = err_cnt_r;
    assign frame_cnt     = frame_cnt_r;
endmodule

// File: tb/tb_tnn_feature_framer.sv
// Directed bench for tnn_feature_framer: reset, framing, back-pressure, framing errors,
// back-to-back throughput, randomised streaming against a reference quantizer, mid-frame reset.
module tb_tnn_feature_framer;
    logic        clk;
    logic        rst;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic [15:0] frame_cnt;
    int          errors;
    int          checks;
    int          cyc;
    logic [14:0] got_q[$];

    tnn_feature_framer_if #(.RAW_W(8), .FEAT_W(3), .N_FEAT(5)) bus_if ();

    tnn_feature_framer #(.RAW_W(8), .FEAT_W(3), .N_FEAT(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output handshakes seen mid-cycle take effect at the following rising edge.
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid && bus_if.out_ready) got_q.push_back(bus_if.out_vec);
    end

    // Independent reference: (d+16)/32, capped at 7.
    function automatic logic [2:0] ref_q(input logic [7:0] d);
        int v;
        v = (int'(d) + 16) / 32;
        if (v > 7) v = 7;
        return 3'(v);
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus_if.in_data  = d;
        bus_if.in_last  = l;
        bus_if.in_valid = 1'b1;
        while (!bus_if.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus_if.in_ready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready=%0b after %0d cycles, required 1", bus_if.in_ready, n);
        end
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [7:0] d4);
        send_beat(d0, 1'b0);
        send_beat(d1, 1'b0);
        send_beat(d2, 1'b0);
        send_beat(d3, 1'b0);
        send_beat(d4, 1'b1);
    endtask

    task automatic pop_frame();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out_vec !== 15'd0 || bus_if.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b vec=%h ready=%0b, required 0/0000/0",
                     bus_if.out_valid, bus_if.out_vec, bus_if.in_ready);
        end
        checks++;
        if (frame_err !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_status: err=%0b err_cnt=%0d frame_cnt=%0d, required 0/0/0",
                     frame_err, err_cnt, frame_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%0b, required 1", bus_if.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        // 0x2F rounds to (47+16)>>5 = 1; 0xF0 saturates to 7.
        send_frame(8'h10, 8'h2F, 8'h50, 8'hAF, 8'hF0);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b111_101_011_001_001) begin
            errors++;
            $display("FAIL basic_frame: valid=%0b vec=%b, required 1 111101011001001",
                     bus_if.out_valid, bus_if.out_vec);
        end
        pop_frame();
        checks++;
        if (bus_if.out_valid !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL basic_handshake: valid=%0b frame_cnt=%0d, required 0/1",
                     bus_if.out_valid, frame_cnt);
        end
    endtask

    task automatic test_back_pressure();
        send_frame(8'h00, 8'h20, 8'h40, 8'h60, 8'h80);
        send_frame(8'hFF, 8'hC0, 8'h9F, 8'h3F, 8'h1F);
        checks++;
        if (bus_if.in_ready !== 1'b0 || bus_if.out_vec !== 15'b100_011_010_001_000) begin
            errors++;
            $display("FAIL bp_enter_hold: ready=%0b vec=%b, required 0 100011010001000",
                     bus_if.in_ready, bus_if.out_vec);
        end
        bus_if.in_data  = 8'h0F;
        bus_if.in_last  = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1 ||
                bus_if.out_vec !== 15'b100_011_010_001_000) begin
                errors++;
                $display("FAIL bp_stall_%0d: ready=%0b valid=%0b vec=%b, required 0 1 100011010001000",
                         i, bus_if.in_ready, bus_if.out_valid, bus_if.out_vec);
            end
        end
        bus_if.in_valid = 1'b0;
        pop_frame();
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b001_010_101_110_111 ||
            bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold_release: valid=%0b vec=%b ready=%0b, required 1 001010101110111 1",
                     bus_if.out_valid, bus_if.out_vec, bus_if.in_ready);
        end
        pop_frame();
        send_frame(8'h0F, 8'h30, 8'h70, 8'hB0, 8'hE0);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b111_110_100_010_000) begin
            errors++;
            $display("FAIL bp_third_frame: valid=%0b vec=%b, required 1 111110100010000",
                     bus_if.out_valid, bus_if.out_vec);
        end
        pop_frame();
        checks++;
        if (frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL bp_frame_cnt: frame_cnt=%0d, required 4", frame_cnt);
        end
    endtask

    task automatic test_short_frame();
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b1);
        checks++;
        if (frame_err !== 1'b1 || err_cnt !== 8'd1 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_err: err=%0b err_cnt=%0d valid=%0b, required 1/1/0",
                     frame_err, err_cnt, bus_if.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse_width: err=%0b, required 0", frame_err);
        end
        send_frame(8'h10, 8'h30, 8'h50, 8'h70, 8'h90);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b101_100_011_010_001) begin
            errors++;
            $display("FAIL short_recover: valid=%0b vec=%b, required 1 101100011010001",
                     bus_if.out_valid, bus_if.out_vec);
        end
        pop_frame();
    endtask

    task automatic test_long_frame();
        for (int i = 0; i < 4; i++) send_beat(8'h40, 1'b0);
        send_beat(8'h40, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL long_err: err=%0b err_cnt=%0d, required 1/2", frame_err, err_cnt);
        end
        send_beat(8'h40, 1'b0);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++;
            $display("FAIL long_drain6: err=%0b, required 0", frame_err);
        end
        send_beat(8'h40, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || bus_if.out_valid !== 1'b0 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL long_drain7: err=%0b valid=%0b err_cnt=%0d, required 0/0/2",
                     frame_err, bus_if.out_valid, err_cnt);
        end
        send_frame(8'h10, 8'h30, 8'h50, 8'h70, 8'h90);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b101_100_011_010_001) begin
            errors++;
            $display("FAIL long_recover: valid=%0b vec=%b, required 1 101100011010001",
                     bus_if.out_valid, bus_if.out_vec);
        end
        pop_frame();
        checks++;
        if (frame_cnt !== 16'd6) begin
            errors++;
            $display("FAIL long_frame_cnt: frame_cnt=%0d, required 6", frame_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        got_q.delete();
        bus_if.out_ready = 1'b1;
        c0 = cyc;
        send_frame(8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        c1 = cyc;
        repeat (2) @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        checks++;
        if (c1 - c0 != 10) begin
            errors++;
            $display("FAIL b2b_cycles: took %0d cycles, required 10", c1 - c0);
        end
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 15'b001_001_001_001_001 ||
            got_q[1] !== 15'b111_111_111_111_111) begin
            errors++;
            $display("FAIL b2b_frames: count=%0d first=%b second=%b, required 2 001001001001001 111111111111111",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 15'd0,
                     (got_q.size() > 1) ? got_q[1] : 15'd0);
        end
        // Last beat lands on the same edge as the pop of the previous frame.
        send_frame(8'h00, 8'h20, 8'h40, 8'h60, 8'h80);
        for (int i = 0; i < 4; i++) send_beat(8'hC0, 1'b0);
        bus_if.out_ready = 1'b1;
        send_beat(8'hC0, 1'b1);
        bus_if.out_ready = 1'b0;
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b110_110_110_110_110 ||
            bus_if.in_ready !== 1'b1 || frame_cnt !== 16'd9) begin
            errors++;
            $display("FAIL simul_pop_load: valid=%0b vec=%b ready=%0b frame_cnt=%0d, required 1 110110110110110 1 9",
                     bus_if.out_valid, bus_if.out_vec, bus_if.in_ready, frame_cnt);
        end
        pop_frame();
        checks++;
        if (frame_cnt !== 16'd10 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame_cnt: frame_cnt=%0d valid=%0b, required 10/0", frame_cnt, bus_if.out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [14:0] exp_q[$];
        logic [14:0] v;
        logic [7:0]  d;
        int          n;
        int          bad;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        bus_if.out_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            v = 15'd0;
            for (int k = 0; k < 5; k++) begin
                d = 8'($urandom_range(0, 255));
                v[k*3 +: 3] = ref_q(d);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send_beat(d, (k == 4) ? 1'b1 : 1'b0);
            end
            exp_q.push_back(v);
        end
        n = 0;
        while (got_q.size() < 100 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        bus_if.out_ready = 1'b0;
        checks++;
        if (got_q.size() != 100) begin
            errors++;
            $display("FAIL stream_count: got %0d frames, required 100", got_q.size());
        end
        bad = 0;
        for (int i = 0; i < 100 && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL stream_frame_%0d: vec=%b, required %b", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (frame_cnt !== 16'd100 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stream_counters: frame_cnt=%0d err_cnt=%0d, required 100/0", frame_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_beat(8'h00, 1'b1);
        send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        send_beat(8'hFF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.out_vec !== 15'd0 || bus_if.in_ready !== 1'b0 ||
            frame_err !== 1'b0 || err_cnt !== 8'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%0b vec=%h ready=%0b err=%0b err_cnt=%0d frame_cnt=%0d, required all 0",
                     bus_if.out_valid, bus_if.out_vec, bus_if.in_ready, frame_err, err_cnt, frame_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: in_ready=%0b, required 1", bus_if.in_ready);
        end
        send_frame(8'h10, 8'h10, 8'h10, 8'h10, 8'h10);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.out_vec !== 15'b001_001_001_001_001 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_fresh: valid=%0b vec=%b err=%0b, required 1 001001001001001 0",
                     bus_if.out_valid, bus_if.out_vec, frame_err);
        end
        pop_frame();
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        cyc              = 0;
        rst              = 1'b1;
        bus_if.in_data   = 8'h00;
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_back_pressure();
        test_short_frame();
        test_long_frame();
        test_back_to_back();
        test_streaming();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
